fpmul_seq: RTL and testbench
============================

// Module: fpmul_seq
// PURPOSE
//  Sequential IEEE-754 binary multiplier with full unpack, iterative mantissa multiply, normalise, round.
//  Successor to the combinational-datapath multiplier: adds reset, valid/ready output handshake,
//  subnormal results, round-to-nearest-even, exception flags and a configurable bits-per-cycle multiply.
//  Sits in the FP execute cluster beside the adder; one operation in flight at a time.
// PARAMETERS
//  LOG_BIT    5               log2 of word width
//  EXP_BIT    8               exponent field width
//  N_BIT      1<<LOG_BIT      word width (derived)
//  MAN_BIT    N_BIT-EXP_BIT-1 stored mantissa width (derived)
//  STEP_BITS  1               multiplier bits retired per MUL cycle; ITER = ceil((MAN_BIT+1)/STEP_BITS)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       asynchronous active-high reset
//  start      in   1       operand valid; accepted when start && ready
//  ready      out  1       1 only in IDLE
//  a, b       in   N_BIT   operands, sampled on accept
//  out        out  N_BIT   result, valid while out_valid
//  out_valid  out  1       result held until out_ready
//  out_ready  in   1       consumer accepts result
//  fflags     out  5       {NV,DZ,OF,UF,NX}; DZ always 0
// BEHAVIOUR
//  Reset (async): state IDLE, ready=1, out_valid=0, out=0, fflags=0; any in-flight op discarded.
//  FSM: IDLE -accept-> MUL (ITER cycles) -> NORM (1) -> RND (1) -> DONE -out_ready-> IDLE.
//   Special operands: IDLE -accept-> DONE directly (out_valid the cycle after accept).
//   Latency accept edge -> out_valid: ITER+3 cycles normal, 1 cycle special.
//  DONE: out/fflags/out_valid stable while out_ready=0; no accept in DONE (ready=0).
//  start while not IDLE ignored. start && ready && rst: rst wins.
//  Unpack: denormal input -> hidden bit 0, effective exponent 1; normal -> hidden bit 1.
//  Exponent path signed EXP_BIT+2 bits: e = ea + eb - BIAS; product 2*MAN_BIT+2 bits.
//  NORM: product MSB set -> shift right 1, e+1; else left-shift by leading-zero count
//   (LZC on product) while e > 1; if e < 1 -> right-shift by 1-e, e = 0 (subnormal),
//   shifted-out bits OR'ed into sticky.
//  RND: guard/round/sticky below MAN_BIT; RNE ties to even. Mantissa carry-out -> e+1;
//   subnormal rounding into hidden bit promotes to min normal.
//  Overflow (e >= all-ones after round): +/-Inf, OF|NX (directed modes may give max finite).
//  UF set when result tiny before rounding and inexact. NX on any discarded nonzero bit.
//  Specials (sign = sa ^ sb unless stated):
//   any NaN -> canonical qNaN 0 | all-ones exp | MSB man 1; NV iff any sNaN.
//   Inf * 0 -> canonical qNaN, NV.  Inf * finite/Inf -> signed Inf, no flags.
//   0 * finite -> signed zero, no flags.
// CONFIGURATION
//  FPMUL_RMODE_EN defined: extra port rm in 3, sampled on accept:
//   000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others -> RNE.
//   Overflow under RTZ, or RDN(+) / RUP(-), -> max finite, OF|NX.
//  Undefined: no rm port; RNE only.
// TESTING (defaults, STEP_BITS=1, ITER=24)
//  0x3FC00000 * 0x40000000 -> out=0x40400000, fflags=0, out_valid exactly 27 cycles after accept.
//  0x3F800001 * 0x3F800001 -> 0x3F800002, fflags=0x01 (NX).
//  0x7F000000 * 0x40000000 -> 0x7F800000, fflags=0x05 (OF|NX).
//  0x7F800000 * 0x00000000 -> 0x7FC00000, fflags=0x10, out_valid 1 cycle after accept.
//  0x00800000 * 0x3F000000 -> 0x00400000, fflags=0. 0x00000001 * 0x3F000000 -> 0x00000000, fflags=0x03.
//  out_ready low 5 cycles in DONE -> out stable, ready=0.
//  rst pulse mid-MUL -> out_valid=0, ready=1 immediately; next op correct.

Source files
------------

// File: rtl/fpmul_seq.sv
// Sequential IEEE-754 multiplier: unpack, shift-add multiply, normalise, round.
// Define FPMUL_RMODE_EN to add the rm port and directed rounding modes.
module fpmul_seq #(
    parameter int LOG_BIT   = 5,
    parameter int EXP_BIT   = 8,
    parameter int N_BIT     = 1 << LOG_BIT,
    parameter int MAN_BIT   = N_BIT - EXP_BIT - 1,
    parameter int STEP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             ready,
    input  logic [N_BIT-1:0] a,
    input  logic [N_BIT-1:0] b,
`ifdef FPMUL_RMODE_EN
    input  logic [2:0]       rm,
`endif
    output logic [N_BIT-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       fflags
);
    localparam int SIG_W = MAN_BIT + 1;
    localparam int PW    = 2 * MAN_BIT + 2;
    localparam int EW    = EXP_BIT + 2;
    localparam int ITER  = (SIG_W + STEP_BITS - 1) / STEP_BITS;
    localparam int MBW   = ITER * STEP_BITS;
    localparam int CW    = $clog2(ITER + 1);
    localparam int LZW   = $clog2(PW + 1);
    localparam int EMAXI = (1 << EXP_BIT) - 1;
    localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_BIT - 1)) - 1);
    localparam logic [N_BIT-1:0] QNAN =
        {1'b0, {EXP_BIT{1'b1}}, 1'b1, {(MAN_BIT - 1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_NORM, S_RND, S_DONE
    } state_t;

    state_t             r_state, w_next;
    logic               r_sign;
    logic [PW-1:0]      r_ma;
    logic [MBW-1:0]     r_mb;
    logic [PW-1:0]      r_prod;
    logic [EW-1:0]      r_e;
    logic [CW-1:0]      r_cnt;
    logic               r_stk;
    logic [N_BIT-1:0]   r_out;
    logic [4:0]         r_flags;
`ifdef FPMUL_RMODE_EN
    logic [2:0]         r_rm;
`endif

    // ---------------- unpack ----------------
    logic [EXP_BIT-1:0] w_ea, w_eb, w_effa, w_effb;
    logic [MAN_BIT-1:0] w_fa, w_fb;
    logic [SIG_W-1:0]   w_sig_a, w_sig_b;
    logic w_a_e1, w_b_e1, w_a_e0, w_b_e0, w_a_m0, w_b_m0;
    logic w_a_nan, w_b_nan, w_a_snan, w_b_snan;
    logic w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic w_sign, w_special;
    logic [EW-1:0]      w_e;
    logic [N_BIT-1:0]   w_sp_res;
    logic [4:0]         w_sp_flg;

    assign w_ea     = a[N_BIT-2 -: EXP_BIT];
    assign w_eb     = b[N_BIT-2 -: EXP_BIT];
    assign w_fa     = a[MAN_BIT-1:0];
    assign w_fb     = b[MAN_BIT-1:0];
    assign w_a_e1   = &w_ea;
    assign w_b_e1   = &w_eb;
    assign w_a_e0   = ~|w_ea;
    assign w_b_e0   = ~|w_eb;
    assign w_a_m0   = ~|w_fa;
    assign w_b_m0   = ~|w_fb;
    assign w_a_nan  = w_a_e1 & ~w_a_m0;
    assign w_b_nan  = w_b_e1 & ~w_b_m0;
    assign w_a_snan = w_a_nan & ~w_fa[MAN_BIT-1];
    assign w_b_snan = w_b_nan & ~w_fb[MAN_BIT-1];
    assign w_a_inf  = w_a_e1 & w_a_m0;
    assign w_b_inf  = w_b_e1 & w_b_m0;
    assign w_a_zero = w_a_e0 & w_a_m0;
    assign w_b_zero = w_b_e0 & w_b_m0;
    assign w_sign   = a[N_BIT-1] ^ b[N_BIT-1];
    assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf
                     | w_a_zero | w_b_zero;

    // Denormals take effective exponent 1 with a clear hidden bit
    assign w_effa  = w_a_e0 ? EXP_BIT'(1) : w_ea;
    assign w_effb  = w_b_e0 ? EXP_BIT'(1) : w_eb;
    assign w_sig_a = {~w_a_e0, w_fa};
    assign w_sig_b = {~w_b_e0, w_fb};
    assign w_e     = {2'b00, w_effa} + {2'b00, w_effb} - BIAS;

    always_comb begin
        w_sp_res = {w_sign, {(N_BIT - 1){1'b0}}};
        w_sp_flg = 5'b0;
        if (w_a_nan | w_b_nan) begin
            w_sp_res    = QNAN;
            w_sp_flg[4] = w_a_snan | w_b_snan;
        end else if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf)) begin
            w_sp_res    = QNAN;
            w_sp_flg[4] = 1'b1;
        end else if (w_a_inf | w_b_inf) begin
            w_sp_res = {w_sign, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
        end
    end

    // ---------------- multiply step ----------------
    logic [PW-1:0] w_pp;

    always_comb begin
        w_pp = '0;
        for (int k = 0; k < STEP_BITS; k++)
            if (r_mb[k]) w_pp = w_pp + (r_ma << k);
    end

    // ---------------- normalise ----------------
    function automatic logic [LZW-1:0] f_lzc(input logic [PW-1:0] v);
        f_lzc = LZW'(PW);
        for (int i = 0; i < PW; i++)
            if (v[i]) f_lzc = LZW'(PW - 1 - i);
    endfunction

    logic [EW-1:0]  w_e1, w_rsh, w_lim, w_sh, w_ne;
    logic [LZW-1:0] w_lz;
    logic [PW-1:0]  w_nm;
    logic           w_nstk;

    // Hidden bit sits at PW-1; exponent 1 with it clear encodes a subnormal
    always_comb begin
        w_e1   = r_e + EW'(1);
        w_lz   = f_lzc(r_prod);
        w_rsh  = '0;
        w_lim  = '0;
        w_sh   = '0;
        w_nm   = '0;
        w_ne   = EW'(1);
        w_nstk = 1'b0;
        if (w_e1[EW-1] || w_e1 == '0) begin
            w_rsh = EW'(1) - w_e1;
            if (w_rsh >= EW'(PW)) begin
                w_nstk = |r_prod;
            end else begin
                w_nm   = r_prod >> w_rsh;
                w_nstk = |(r_prod & ((PW'(1) << w_rsh) - PW'(1)));
            end
        end else begin
            w_lim = w_e1 - EW'(1);
            w_sh  = (EW'(w_lz) > w_lim) ? w_lim : EW'(w_lz);
            w_nm  = r_prod << w_sh;
            w_ne  = w_e1 - w_sh;
        end
    end

    // ---------------- round ----------------
    logic [SIG_W-1:0]   w_kept, w_rman;
    logic [SIG_W:0]     w_sum;
    logic               w_g, w_s, w_inx, w_inc, w_ovf, w_maxf, w_tiny;
    logic [EW-1:0]      w_re;
    logic [EXP_BIT-1:0] w_fe;
    logic [N_BIT-1:0]   w_res;
    logic [4:0]         w_flg;

    assign w_kept = r_prod[PW-1 -: SIG_W];
    assign w_g    = r_prod[PW-SIG_W-1];
    assign w_s    = (|r_prod[PW-SIG_W-2:0]) | r_stk;
    assign w_inx  = w_g | w_s;
    assign w_tiny = ~r_prod[PW-1];

    always_comb begin
        w_inc  = w_g & (w_s | w_kept[0]);
        w_maxf = 1'b0;
`ifdef FPMUL_RMODE_EN
        unique case (r_rm)
            3'b001: begin
                w_inc  = 1'b0;
                w_maxf = 1'b1;
            end
            3'b010: begin
                w_inc  = r_sign & w_inx;
                w_maxf = ~r_sign;
            end
            3'b011: begin
                w_inc  = ~r_sign & w_inx;
                w_maxf = r_sign;
            end
            3'b100:  w_inc = w_g;
            default: w_inc = w_g & (w_s | w_kept[0]);
        endcase
`endif
    end

    always_comb begin
        w_sum  = {1'b0, w_kept} + {{SIG_W{1'b0}}, w_inc};
        w_rman = w_sum[SIG_W-1:0];
        w_re   = r_e;
        if (w_sum[SIG_W]) begin
            w_rman = w_sum[SIG_W:1];
            w_re   = r_e + EW'(1);
        end
        w_fe  = w_rman[SIG_W-1] ? w_re[EXP_BIT-1:0] : '0;
        w_ovf = w_rman[SIG_W-1] && (w_re >= EW'(EMAXI));
        w_res = {r_sign, w_fe, w_rman[MAN_BIT-1:0]};
        w_flg = {3'b000, w_tiny & w_inx, w_inx};
        if (w_ovf) begin
            w_flg = 5'b00101;
            if (w_maxf)
                w_res = {r_sign, EXP_BIT'(EMAXI - 1), {MAN_BIT{1'b1}}};
            else
                w_res = {r_sign, {EXP_BIT{1'b1}}, {MAN_BIT{1'b0}}};
        end
    end

    // ---------------- control ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = w_special ? S_DONE : S_MUL;
            S_MUL:   if (r_cnt == '0) w_next = S_NORM;
            S_NORM:  w_next = S_RND;
            S_RND:   w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sign  <= 1'b0;
            r_ma    <= '0;
            r_mb    <= '0;
            r_prod  <= '0;
            r_e     <= '0;
            r_cnt   <= '0;
            r_stk   <= 1'b0;
            r_out   <= '0;
            r_flags <= '0;
`ifdef FPMUL_RMODE_EN
            r_rm    <= '0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: if (start) begin
                    r_sign <= w_sign;
                    r_ma   <= PW'(w_sig_a);
                    r_mb   <= MBW'(w_sig_b);
                    r_prod <= '0;
                    r_e    <= w_e;
                    r_cnt  <= CW'(ITER);
                    r_stk  <= 1'b0;
`ifdef FPMUL_RMODE_EN
                    r_rm   <= rm;
`endif
                    if (w_special) begin
                        r_out   <= w_sp_res;
                        r_flags <= w_sp_flg;
                    end
                end
                S_MUL: if (r_cnt != '0) begin
                    r_prod <= r_prod + w_pp;
                    r_ma   <= r_ma << STEP_BITS;
                    r_mb   <= r_mb >> STEP_BITS;
                    r_cnt  <= r_cnt - CW'(1);
                end
                S_NORM: begin
                    r_prod <= w_nm;
                    r_e    <= w_ne;
                    r_stk  <= w_nstk;
                end
                S_RND: begin
                    r_out   <= w_res;
                    r_flags <= w_flg;
                end
                default: ;
            endcase
        end
    end

    assign ready     = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out       = r_out;
    assign fflags    = r_flags;

endmodule

// File: tb/tb_fpmul_seq.sv
// Self-checking bench for fpmul_seq: directed vectors, stall, reset, random ops.
// Random results come from an exact integer product model with RNE rounding.
module tb_fpmul_seq;
    localparam int STEP = 1;
    localparam int ITER = (24 + STEP - 1) / STEP;
    localparam int NLAT = ITER + 3;

    logic        clk, rst, start, ready, out_valid, out_ready;
    logic [31:0] a, b, y;
    logic [4:0]  fflags;
`ifdef FPMUL_RMODE_EN
    logic [2:0]  rm;
`endif
    int total = 0;
    int bad = 0;

    fpmul_seq #(.STEP_BITS(STEP)) dut (
        .clk(clk), .rst(rst), .start(start), .ready(ready),
        .a(a), .b(b),
`ifdef FPMUL_RMODE_EN
        .rm(rm),
`endif
        .out(y), .out_valid(out_valid), .out_ready(out_ready),
        .fflags(fflags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Exact product p * 2^xe, then quantise to the binary32 grid with RNE
    task automatic ref_mul(input logic [31:0] x, input logic [31:0] z,
                           output logic [31:0] r, output logic [4:0] f,
                           output bit sp);
        int ex, ez, n, xe, e, q, sh, be;
        longint unsigned mx, mz, p, mant, rem, half;
        bit s, nx, nz, snx, snz, ix, iz, zx, zz, inx;
        s   = x[31] ^ z[31];
        ex  = int'(x[30:23]);
        ez  = int'(z[30:23]);
        nx  = (ex == 255) && (x[22:0] != 0);
        nz  = (ez == 255) && (z[22:0] != 0);
        snx = nx && !x[22];
        snz = nz && !z[22];
        ix  = (ex == 255) && (x[22:0] == 0);
        iz  = (ez == 255) && (z[22:0] == 0);
        zx  = (ex == 0) && (x[22:0] == 0);
        zz  = (ez == 0) && (z[22:0] == 0);
        sp  = nx || nz || ix || iz || zx || zz;
        r   = {s, 31'b0};
        f   = 5'b0;
        if (nx || nz) begin
            r = 32'h7FC00000;
            f = {snx || snz, 4'b0};
        end else if ((ix && zz) || (zx && iz)) begin
            r = 32'h7FC00000;
            f = 5'b10000;
        end else if (ix || iz) begin
            r = {s, 8'hFF, 23'b0};
        end else if (!sp) begin
            mx = (ex == 0) ? 64'(x[22:0]) : 64'({1'b1, x[22:0]});
            mz = (ez == 0) ? 64'(z[22:0]) : 64'({1'b1, z[22:0]});
            if (ex == 0) ex = 1;
            if (ez == 0) ez = 1;
            p  = mx * mz;
            xe = ex + ez - 254 - 46;
            n  = 0;
            for (int i = 0; i < 64; i++) if (p[i]) n = i;
            e  = n + xe + 127;
            q  = ((e >= 1) ? e : 1) - 150;
            sh = q - xe;
            if (sh <= 0) begin
                mant = p << (-sh);
                inx  = 0;
            end else if (sh > 62) begin
                mant = 0;
                inx  = 1;
            end else begin
                mant = p >> sh;
                rem  = p & ((64'd1 << sh) - 64'd1);
                half = 64'd1 << (sh - 1);
                inx  = (rem != 0);
                if (rem > half || (rem == half && mant[0])) mant++;
            end
            if (mant == (64'd1 << 24)) begin
                mant = 64'd1 << 23;
                q++;
            end
            be = mant[23] ? q + 150 : 0;
            if (be >= 255) begin
                r = {s, 8'hFF, 23'b0};
                f = 5'b00101;
            end else begin
                r = {s, 8'(be), mant[22:0]};
                f = {3'b000, (e < 1) && inx, inx};
            end
        end
    endtask

    // Leaves the DUT holding its result in DONE
    task automatic run_op(input string tag, input logic [31:0] x,
                          input logic [31:0] z, input logic [31:0] er,
                          input logic [4:0] ef, input int elat);
        int lat;
        @(negedge clk);
        chk({tag, "_rdy"}, {31'b0, ready}, 32'd1);
        a = x;
        b = z;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        a = $urandom;
        b = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 200);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_out"}, y, er);
        chk({tag, "_flg"}, {27'b0, fflags}, {27'b0, ef});
    endtask

    task automatic release_op(input string tag);
        @(negedge clk);
        out_ready = 1;
        @(posedge clk);
        #1;
        out_ready = 0;
        chk({tag, "_idle"}, {31'b0, ready}, 32'd1);
    endtask

    logic [31:0] ta [12] = '{
        32'h3FC00000, 32'h3F800001, 32'h7F000000, 32'h7F800000,
        32'h00800000, 32'h00000001, 32'h7F800001, 32'hFFC00000,
        32'hFF800000, 32'h80000000, 32'hC0000000, 32'h00000001};
    logic [31:0] tb_ [12] = '{
        32'h40000000, 32'h3F800001, 32'h40000000, 32'h00000000,
        32'h3F000000, 32'h3F000000, 32'h3F800000, 32'h3F800000,
        32'h40000000, 32'h40A00000, 32'h40400000, 32'h00000001};
    logic [31:0] tr [12] = '{
        32'h40400000, 32'h3F800002, 32'h7F800000, 32'h7FC00000,
        32'h00400000, 32'h00000000, 32'h7FC00000, 32'h7FC00000,
        32'hFF800000, 32'h80000000, 32'hC0C00000, 32'h00000000};
    logic [4:0] tf [12] = '{
        5'h00, 5'h01, 5'h05, 5'h10, 5'h00, 5'h03,
        5'h10, 5'h00, 5'h00, 5'h00, 5'h00, 5'h03};
    int tl [12] = '{NLAT, NLAT, NLAT, 1, NLAT, NLAT,
                    1, 1, 1, 1, NLAT, NLAT};

    function automatic logic [31:0] rnd_op(input int mode);
        logic [31:0] v;
        v = $urandom;
        case (mode)
            1: v[30:23] = 8'($urandom_range(107, 147));
            2: v[30:23] = 8'($urandom_range(0, 12));
            3: v[30:23] = 8'($urandom_range(200, 254));
            default: ;
        endcase
        return v;
    endfunction

    initial begin
        logic [31:0] ra, rb, er;
        logic [4:0]  ef;
        bit          sp;
        clk = 0;
        rst = 1;
        start = 0;
        a = 0;
        b = 0;
        out_ready = 0;
`ifdef FPMUL_RMODE_EN
        rm = 3'b000;
`endif
        #12;
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out", y, 32'd0);
        chk("rst_flags", {27'b0, fflags}, 32'd0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("dir%0d", i), ta[i], tb_[i], tr[i], tf[i], tl[i]);
            release_op($sformatf("dir%0d", i));
        end

        run_op("stall", 32'h3FC00000, 32'h40000000, 32'h40400000, 5'h00, NLAT);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1;
            a = 32'h7F800000;
            b = 32'h00000000;
            #1;
            chk("stall_out", y, 32'h40400000);
            chk("stall_flg", {27'b0, fflags}, 32'd0);
            chk("stall_vld", {31'b0, out_valid}, 32'd1);
            chk("stall_rdy", {31'b0, ready}, 32'd0);
        end
        start = 0;
        release_op("stall");

        @(negedge clk);
        a = 32'h3F800001;
        b = 32'h3F800001;
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        chk("mrst_vld", {31'b0, out_valid}, 32'd0);
        chk("mrst_rdy", {31'b0, ready}, 32'd1);
        chk("mrst_out", y, 32'd0);
        @(negedge clk);
        rst = 0;
        run_op("post_rst", 32'h40400000, 32'h40400000, 32'h41100000, 5'h00, NLAT);
        release_op("post_rst");

        for (int i = 0; i < 60; i++) begin
            ra = rnd_op($urandom_range(0, 3));
            rb = rnd_op($urandom_range(0, 3));
            ref_mul(ra, rb, er, ef, sp);
            run_op($sformatf("rnd%0d_%h_%h", i, ra, rb), ra, rb, er, ef,
                   sp ? 1 : NLAT);
            release_op($sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
